// File: rtl/cube_if.sv
// Start/busy handshake bundle for the iterative cube unit.
// The master drives the operand and request; the slave returns result, busy and done.
interface cube_if;
    logic [7:0]  x_i;
    logic        start;
    logic [23:0] result;
    logic        busy;
    logic        done;

    modport master (
        output x_i,
        output start,
        input  result,
        input  busy,
        input  done
    );

    modport slave (
        input  x_i,
        input  start,
        output result,
        output busy,
        output done
    );
endinterface

// File: rtl/cube.sv
// Iterative 8-bit cube: two back-to-back 8-step shift-add multiplies (x*x, then sq*x).
// Latency is a fixed 16 busy cycles; done pulses in the first cycle the new result is held.
module cube (
    input  logic   clk,
    input  logic   rst,
    cube_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ   = 2'd1,
        CB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [23:0] mcand_q, mcand_d;
    logic [23:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [23:0] result_q, result_d;
    logic        done_q, done_d;
    logic [23:0] sum;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        sum      = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d      = bus.x_i;
                    mplier_d = bus.x_i;
                    mcand_d  = {16'd0, bus.x_i};
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = SQ;
                end
            end
            SQ, CB: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    if (state_q == SQ) begin
                        // The square needs no register of its own: it is carried
                        // in mcand for the whole CB pass.
                        mcand_d  = {8'd0, sum[15:0]};
                        mplier_d = x_q;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = CB;
                    end else begin
                        result_d = sum;
                        done_d   = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = done_q;
endmodule

// File: tb/tb_cube.sv
// Self-checking bench for cube: arithmetic reference (n*n*n), cycle-count timing
// checks, randomized operands and noise on the inputs while busy.
module tb_cube;
    logic clk = 1'b0;
    logic rst = 1'b0;
    cube_if bus();

    cube dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned ref_cube(input int unsigned v);
        return v * v * v;
    endfunction

    function automatic int unsigned ref_cbrt(input int unsigned v);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic run_op(input logic [7:0] x, input bit noisy);
        int unsigned c = 0;
        bus.x_i   = x;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("accept_busy", {31'd0, bus.busy}, 32'd1);
        while (!bus.done && c < 40) begin
            if (noisy) begin
                bus.x_i   = 8'($urandom);
                bus.start = 1'($urandom_range(0, 1));
            end
            tick();
            c++;
        end
        bus.start = 1'b0;
        check_eq("latency", c, 32'd16);
        check_eq("busy_at_done", {31'd0, bus.busy}, 32'd0);
        check_eq("result", {8'd0, bus.result}, ref_cube(x));
        tick();
        check_eq("done_one_cycle", {31'd0, bus.done}, 32'd0);
        check_eq("result_held", {8'd0, bus.result}, ref_cube(x));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned ndone;
        int unsigned c;
        logic [7:0] rx;

        // Reset held with start high: request must be dropped.
        bus.x_i   = 8'd77;
        bus.start = 1'b1;
        repeat (3) tick();
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst_done", {31'd0, bus.done}, 32'd0);
        check_eq("rst_result", {8'd0, bus.result}, 32'd0);
        bus.start = 1'b0;
        rst = 1'b1;
        tick();
        check_eq("post_rst_idle", {31'd0, bus.busy}, 32'd0);

        run_op(8'd0, 1'b0);
        run_op(8'd1, 1'b0);
        run_op(8'd5, 1'b0);
        run_op(8'd255, 1'b0);

        // start while busy is ignored, never queued.
        bus.x_i = 8'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.x_i = 8'd200; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.done) ndone++;
        end
        check_eq("ignore_ndone", ndone, 32'd1);
        check_eq("ignore_result", {8'd0, bus.result}, 32'd27);
        check_eq("ignore_idle", {31'd0, bus.busy}, 32'd0);

        // Reset at cycle 10 of an operation aborts it.
        bus.x_i = 8'd9; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        rst = 1'b0;
        tick();
        check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("abort_result", {8'd0, bus.result}, 32'd0);
        check_eq("abort_done", {31'd0, bus.done}, 32'd0);
        rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done) ndone++;
        end
        check_eq("abort_no_done", ndone, 32'd0);
        run_op(8'd9, 1'b0);

        // Round trip through a reference cube root.
        for (int k = 0; k <= 6; k++) begin
            run_op(8'(k), 1'b0);
            check_eq("round_trip", ref_cbrt(32'(bus.result)), 32'(k));
        end

        // Random operands with input noise while busy.
        for (int i = 0; i < 16; i++) begin
            rx = 8'($urandom);
            run_op(rx, 1'b1);
        end

        // Exhaustive sweep with start held high: spacing 17 cycles.
        bus.x_i   = 8'd0;
        bus.start = 1'b1;
        for (int n = 0; n < 256; n++) begin
            tick();
            c = 1;
            check_eq("sweep_accept", {31'd0, bus.busy}, 32'd1);
            bus.x_i = 8'(n + 1);
            while (!bus.done && c < 40) begin
                tick();
                c++;
            end
            check_eq("sweep_spacing", c, 32'd17);
            check_eq("sweep_result", {8'd0, bus.result}, ref_cube(32'(n)));
        end
        bus.start = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
